// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - state encoding and period constants shared by the pwm_ratio_gen slice
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } pwm_state_t;

  localparam logic [7:0] PERIOD_MAX   = 8'd254;
  localparam int         DEAD_PERIODS = 1;

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - emits one tick every prescale+1 clocks while run is high
module pwm_prescaler (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] prescale,
  input  logic       run,
  output logic       tick
);

  logic [7:0] count;

  assign tick = run && (count == prescale);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (!run || tick) begin
      count <= 8'd0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/pwm_ratio_gen.sv
// rtl/pwm_ratio_gen.sv - 255-tick PWM with boundary-synchronised ratio/direction updates
// Define PWM_DEADTIME_EN to insert a dead period on direction reversal.
module pwm_ratio_gen
  import pwm_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  input  logic [7:0] prescale,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       dir_out
);

  pwm_state_t state;
  logic [7:0] prescale_q;
  logic [7:0] period_count;
  logic [7:0] active_ratio;
  logic [7:0] pending_ratio;
  logic       pending_dir;
  logic       pending_valid;
  logic       run;
  logic       tick;
  logic       boundary;
  logic       has_load;
  logic [7:0] load_ratio;
  logic       load_dir;

`ifdef PWM_DEADTIME_EN
  localparam logic [1:0] DEAD_LAST = 2'(DEAD_PERIODS - 1);
  logic       dead_dir;
  logic [1:0] dead_count;
`endif

  // Counters only move while enabled and out of IDLE, so they sit at 0 otherwise.
  assign run      = pwm_enable && (state != IDLE);
  assign boundary = tick && (period_count == PERIOD_MAX);

  pwm_prescaler u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .prescale (prescale_q),
    .run      (run),
    .tick     (tick)
  );

  // A same-cycle update bypasses the pending registers.
  always_comb begin
    has_load   = pwm_update || pending_valid;
    load_ratio = pwm_update ? pwm_ratio     : pending_ratio;
    load_dir   = pwm_update ? pwm_direction : pending_dir;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      prescale_q    <= 8'd0;
      period_count  <= 8'd0;
      active_ratio  <= 8'd0;
      pending_ratio <= 8'd0;
      pending_dir   <= 1'b0;
      pending_valid <= 1'b0;
      pwm_out       <= 1'b0;
      dir_out       <= 1'b0;
      pwm_done      <= 1'b0;
`ifdef PWM_DEADTIME_EN
      dead_dir      <= 1'b0;
      dead_count    <= 2'd0;
`endif
    end else begin
      pwm_done <= 1'b0;
      if (!pwm_enable) begin
        state         <= IDLE;
        period_count  <= 8'd0;
        active_ratio  <= 8'd0;
        pending_valid <= 1'b0;
        pwm_out       <= 1'b0;
`ifdef PWM_DEADTIME_EN
        dead_count    <= 2'd0;
`endif
      end else if (state == IDLE) begin
        state        <= RUN;
        prescale_q   <= prescale;
        period_count <= 8'd0;
        pwm_out      <= 1'b0;
      end else begin
        pwm_out <= (state == RUN) && (period_count < active_ratio);
        if (pwm_update) begin
          pending_ratio <= pwm_ratio;
          pending_dir   <= pwm_direction;
          pending_valid <= 1'b1;
        end
        if (tick) begin
          period_count <= boundary ? 8'd0 : period_count + 8'd1;
        end
        if (boundary) begin
          prescale_q <= prescale;
`ifdef PWM_DEADTIME_EN
          if (state == DEAD) begin
            // Leaving DEAD applies anything queued meanwhile, silently.
            if (dead_count == DEAD_LAST) begin
              state      <= RUN;
              dead_count <= 2'd0;
              if (has_load) begin
                active_ratio  <= load_ratio;
                dir_out       <= load_dir;
                pending_valid <= 1'b0;
              end else begin
                dir_out <= dead_dir;
              end
            end else begin
              dead_count <= dead_count + 2'd1;
            end
          end else if (has_load) begin
            active_ratio  <= load_ratio;
            pwm_done      <= 1'b1;
            pending_valid <= 1'b0;
            if (load_dir != dir_out) begin
              state      <= DEAD;
              dead_dir   <= load_dir;
              dead_count <= 2'd0;
            end else begin
              dir_out <= load_dir;
            end
          end
`else
          if (has_load) begin
            active_ratio  <= load_ratio;
            dir_out       <= load_dir;
            pwm_done      <= 1'b1;
            pending_valid <= 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: doc/pwm_ratio_gen.md
PWM_RATIO_GEN -- requirements
Module: pwm_ratio_gen

Interface
REQ-001 SHALL have port: clock  input  1  main clock.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: pwm_enable  input  1  run enable; low forces IDLE.
REQ-004 SHALL have port: pwm_update  input  1  level request; new ratio/direction pending.
REQ-005 SHALL have port: pwm_ratio  input  8  requested high-time, out of 255 ticks.
REQ-006 SHALL have port: pwm_direction  input  1  requested motor direction.
REQ-007 SHALL have port: prescale  input  8  clock cycles per tick, minus 1.
REQ-008 SHALL have port: pwm_done  output  1  one-cycle pulse; pending values applied.
REQ-009 SHALL have port: pwm_out  output  1  registered PWM drive.
REQ-010 SHALL have port: dir_out  output  1  registered direction drive.

Function
REQ-011 SHALL use states IDLE, RUN, DEAD. IDLE -> RUN when pwm_enable high. Any state -> IDLE on the cycle after pwm_enable goes low.
REQ-012 Prescaler SHALL count 0..prescale. It emits a tick on the cycle where count == prescale, then wraps to 0. prescale=0 gives a tick every cycle.
REQ-013 Period counter SHALL advance 0..254 on ticks. A boundary is a tick at count 254, after which the counter wraps to 0. Period = 255 ticks.
REQ-014 Each cycle pwm_update is high, the block SHALL capture pwm_ratio and pwm_direction into pending registers and set pending_valid.
REQ-015 At a boundary with pending_valid set, the block SHALL:
  - copy the pending values to the active registers;
  - pulse pwm_done high for exactly 1 cycle;
  - clear pending_valid.
  If pwm_update is still high, pending_valid re-sets on the next cycle.
REQ-016 If pwm_update is high in the same cycle as a boundary, the current input values SHALL be loaded directly (bypass) and pwm_done SHALL pulse.
REQ-017 At a boundary with no pending values, active values SHALL be held and pwm_done SHALL remain low.
REQ-018 In RUN, pwm_out SHALL equal (period_count < active_ratio), registered (1-cycle latency).
  - ratio 0: constantly low.
  - ratio 255: constantly high.
REQ-019 prescale SHALL be sampled only at boundaries and on IDLE -> RUN.
REQ-020 In IDLE:
  - pwm_out = 0 and pwm_done = 0;
  - counters held at 0;
  - pending_valid cleared;
  - active ratio = 0;
  - dir_out holds its last value.
REQ-021 The first boundary after IDLE -> RUN SHALL occur 255*(prescale+1) cycles after entry.

Reset
REQ-022 While reset_n is low, the block SHALL drive:
  - pwm_out = 0, dir_out = 0, pwm_done = 0;
  - state = IDLE;
  - all counters, pending and active registers = 0.
REQ-023 Reset mid-period SHALL discard pending values. After release the block SHALL resume from IDLE.

Configuration
REQ-024 Macro PWM_DEADTIME_EN SHALL select direction-reversal handling.
  - Defined: a boundary load where the new direction != dir_out SHALL enter DEAD for one full period. In DEAD, pwm_out = 0 and dir_out is unchanged. At the next boundary dir_out SHALL take the new direction and the state returns to RUN. pwm_done pulses at the original load.
  - Undefined: no DEAD state; dir_out SHALL update at the load boundary.
REQ-025 pwm_update received during DEAD SHALL remain pending and be applied at the DEAD-exit boundary without an extra pwm_done pulse.

Structure
REQ-026 Shared package pwm_pkg SHALL hold the state encoding, PERIOD_MAX = 254 and DEAD_PERIODS = 1.
REQ-027 Prescaler SHALL be the sub-module pwm_prescaler (inputs prescale and run; output tick).

Verification
REQ-028 prescale=0, ratio=64 via pwm_update, enable -> first boundary loads ratio; pwm_out high 64 of every 255 cycles; pwm_done one 1-cycle pulse.
REQ-029 pwm_update held high, ratio stepped 10 -> 20 -> 30 -> exactly one pwm_done per period; each new ratio visible from the following period.
REQ-030 ratio=0 then ratio=255 -> pwm_out constantly 0, then constantly 1, with no glitch at the wrap.
REQ-031 PWM_DEADTIME_EN defined, dir 0 -> 1 at ratio=128 -> one full period with pwm_out=0; dir_out=1 thereafter. Undefined: immediate switch.
REQ-032 pwm_enable dropped mid-period at ratio=200 -> pwm_out=0 next cycle; counters 0; re-enable restarts with a fresh period.
REQ-033 reset_n asserted mid-period with pending update -> all outputs 0; no pwm_done after release until a new pwm_update.
